// File: rtl/data_mem_arbiter_if.sv
// Two-requester data_mem port bundle: requester side (master) and arbiter side (slave).
// Carries both request ports, their read-return paths and the shared memory port.
interface data_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32
);
  logic                     req0;
  logic                     req1;
  logic [3:0]               be0;
  logic [3:0]               be1;
  logic [ADDRESS_WIDTH-1:0] addr0;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0]    wdata0;
  logic [DATA_WIDTH-1:0]    wdata1;
  logic                     gnt0;
  logic                     gnt1;
  logic                     rvalid0;
  logic                     rvalid1;
  logic [DATA_WIDTH-1:0]    rdata0;
  logic [DATA_WIDTH-1:0]    rdata1;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [3:0]               mem_we;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport master (
    output req0, req1, be0, be1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_a, mem_wd, mem_we
  );

  modport slave (
    input  req0, req1, be0, be1, addr0, addr1, wdata0, wdata1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Sticky-owner, burst-capped arbiter sharing data_mem between core (port 0) and debug (port 1).
// Grant is combinational; read data returns one cycle after the read grant. Losers simply wait.
// Optional perf counters enabled by ARB_PERF_CNT_EN.
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 4
`ifdef ARB_PERF_CNT_EN
  , parameter int CNT_WIDTH   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] conflict_cnt
  , output logic [CNT_WIDTH-1:0] grant_cnt0
  , output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t               state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 arb_gnt0, arb_gnt1;
  logic                 gnt0, gnt1;
  logic                 rd_req0, rd_req1;
  logic                 rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    arb_gnt0     = 1'b0;
    arb_gnt1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the port that did not own last wins.
        if (bus.req0 && (!bus.req1 || last_owner_q)) begin
          arb_gnt0 = 1'b1;
          state_d  = OWN0;
          burst_d  = BURST_ONE;
        end else if (bus.req1) begin
          arb_gnt1 = 1'b1;
          state_d  = OWN1;
          burst_d  = BURST_ONE;
        end
      end
      OWN0: begin
        if (bus.req0 && !(bus.req1 && burst_q == BURST_MAX)) begin
          arb_gnt0 = 1'b1;
          if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
        end else if (bus.req1) begin
          arb_gnt1     = 1'b1;
          state_d      = OWN1;
          burst_d      = BURST_ONE;
          last_owner_d = 1'b0;
        end else begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (bus.req1 && !(bus.req0 && burst_q == BURST_MAX)) begin
          arb_gnt1 = 1'b1;
          if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
        end else if (bus.req0) begin
          arb_gnt0     = 1'b1;
          state_d      = OWN0;
          burst_d      = BURST_ONE;
          last_owner_d = 1'b1;
        end else begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must suppress any memory access in the same cycle, not just the next one.
  assign gnt0 = arb_gnt0 & ~rst;
  assign gnt1 = arb_gnt1 & ~rst;
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  always_comb begin
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    bus.mem_we = 4'b0000;
    if (gnt0) begin
      bus.mem_a  = bus.addr0;
      bus.mem_wd = bus.wdata0;
      bus.mem_we = bus.be0;
    end else if (gnt1) begin
      bus.mem_a  = bus.addr1;
      bus.mem_wd = bus.wdata1;
      bus.mem_we = bus.be1;
    end
  end

  assign rd_req0 = gnt0 && (bus.be0 == 4'b0000);
  assign rd_req1 = gnt1 && (bus.be1 == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd_req0;
      rvalid1_q <= rd_req1;
      if (rd_req0) rdata0_q <= bus.mem_rd;
      if (rd_req1) rdata1_q <= bus.mem_rd;
    end
  end

  // A read granted just before reset must not surface during the reset cycle.
  assign bus.rvalid0 = rvalid0_q & ~rst;
  assign bus.rvalid1 = rvalid1_q & ~rst;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

`ifdef ARB_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
    end else begin
      if (((bus.req0 && !gnt0) || (bus.req1 && !gnt1)) && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + CNT_ONE;
      if (gnt0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_ONE;
      if (gnt1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_ONE;
    end
  end
`endif

endmodule
